// File: rtl/mem_arbiter.sv
// mem_arbiter
// Single-port controller sitting between the instruction fetcher, the
// load/store buffer and a byte-wide unified RAM. One request at a time is
// turned into 1..4 byte accesses, lowest address first, and the assembled
// little-endian word is handed back to whoever asked.
//
// Ports
//   clk_in, rst_in, rdy_in   clock, sync active-high reset, global freeze (low)
//   clear_in                 pipeline flush: aborts reads, blocks new accepts
//   if_req/if_addr           fetch request (level) and byte address
//   if_ack/if_done/if_data   fetch accepted pulse, data-valid pulse, word
//   lsb_go_work ...          LSB request: load/store, width, address, data
//   lsb_received             LSB accepted pulse
//   lsb_has_result           LSB completion pulse, lsb_value_load = load data
//   mem_din/mem_dout/mem_a   RAM read data (one cycle latency), write data, address
//   mem_wr                   RAM write strobe
//   io_buffer_full           I/O FIFO full; stalls stores into the I/O window
module mem_arbiter #(
  parameter logic [31:0] IO_BASE = 32'h00030000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear_in,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        lsb_go_work,
  input  logic        lsb_l_or_s,
  input  logic [2:0]  lsb_width,
  input  logic [31:0] lsb_address,
  input  logic [31:0] lsb_value_store,
  output logic        lsb_received,
  output logic        lsb_has_result,
  output logic [31:0] lsb_value_load,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  localparam logic GRANT_FETCH = 1'b0;
  localparam logic GRANT_LSB   = 1'b1;

  // Replace byte idx of a word.
  function automatic logic [31:0] put_byte(input logic [31:0] w,
                                           input logic [1:0]  idx,
                                           input logic [7:0]  b);
    logic [31:0] r;
    r = w;
    r[{idx, 3'b000} +: 8] = b;
    return r;
  endfunction

  // Extract byte idx of a word.
  function automatic logic [7:0] byte_of(input logic [31:0] w,
                                         input logic [1:0]  idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

  // Address falls in the 8-byte I/O window (wrap-safe via subtraction).
  function automatic logic in_io(input logic [31:0] a);
    logic [31:0] off;
    off = a - IO_BASE;
    return (off < 32'd8);
  endfunction

  logic [1:0]  state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        owner_q, owner_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  width_q, width_d;
  logic [31:0] store_q, store_d;
  logic [2:0]  k_q, k_d;
  logic [31:0] buf_q, buf_d;
  logic        if_ack_q, if_ack_d;
  logic        if_done_q, if_done_d;
  logic [31:0] if_data_q, if_data_d;
  logic        lsb_received_q, lsb_received_d;
  logic        lsb_has_result_q, lsb_has_result_d;
  logic [31:0] lsb_value_load_q, lsb_value_load_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic        mem_wr_q, mem_wr_d;

  logic        grant_lsb_s;
  logic [31:0] req_addr_s;
  logic [2:0]  req_width_s;
  logic [31:0] req_store_s;
  logic        req_is_store_s;
  logic [2:0]  k_next_s;
  logic [2:0]  rd_idx_s;
  logic [31:0] buf_next_s;
  logic        io_stall_s;

  // LSB wins when alone, or on a tie when fetch had the last grant.
  assign grant_lsb_s    = lsb_go_work && (!if_req || (last_grant_q == GRANT_FETCH));
  assign req_addr_s     = grant_lsb_s ? lsb_address : if_addr;
  assign req_width_s    = grant_lsb_s ? ((lsb_width > 3'd4) ? 3'd4 : lsb_width) : 3'd4;
  assign req_store_s    = grant_lsb_s ? lsb_value_store : 32'd0;
  assign req_is_store_s = grant_lsb_s && lsb_l_or_s;
  assign k_next_s       = k_q + 3'd1;
  assign rd_idx_s       = k_q - 3'd1;
  assign io_stall_s     = in_io(addr_q) && io_buffer_full;

  // Next-state logic for the access sequencer.
  always_comb begin
    state_d          = state_q;
    last_grant_d     = last_grant_q;
    owner_d          = owner_q;
    addr_d           = addr_q;
    width_d          = width_q;
    store_d          = store_q;
    k_d              = k_q;
    buf_d            = buf_q;
    if_ack_d         = 1'b0;
    if_done_d        = 1'b0;
    if_data_d        = if_data_q;
    lsb_received_d   = 1'b0;
    lsb_has_result_d = 1'b0;
    lsb_value_load_d = lsb_value_load_q;
    mem_dout_d       = mem_dout_q;
    mem_a_d          = mem_a_q;
    mem_wr_d         = 1'b0;
    // In READ, byte k-1 arrives on mem_din at the edge where k_q == k.
    if (k_q != 3'd0) begin
      buf_next_s = put_byte(buf_q, rd_idx_s[1:0], mem_din);
    end else begin
      buf_next_s = buf_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (!clear_in && (if_req || lsb_go_work)) begin
          last_grant_d   = grant_lsb_s ? GRANT_LSB : GRANT_FETCH;
          owner_d        = grant_lsb_s;
          addr_d         = req_addr_s;
          width_d        = req_width_s;
          store_d        = req_store_s;
          k_d            = 3'd0;
          buf_d          = 32'd0;
          if_ack_d       = !grant_lsb_s;
          lsb_received_d = grant_lsb_s;
          mem_a_d        = req_addr_s;
          if (req_width_s == 3'd0) begin
            // Null access completes through WRITE without RAM traffic.
            state_d = ST_WRITE;
          end else if (req_is_store_s) begin
            state_d    = ST_WRITE;
            mem_dout_d = req_store_s[7:0];
            mem_wr_d   = !(in_io(req_addr_s) && io_buffer_full);
          end else begin
            state_d = ST_READ;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_READ: begin
        if (clear_in) begin
          state_d          = ST_IDLE;
          if_data_d        = 32'd0;
          lsb_value_load_d = 32'd0;
          mem_a_d          = 32'd0;
        end else begin
          k_d   = k_next_s;
          buf_d = buf_next_s;
          if (k_next_s < width_q) begin
            mem_a_d = addr_q + {29'd0, k_next_s};
          end else begin
            mem_a_d = mem_a_q;
          end
          if (k_q == width_q) begin
            state_d = ST_IDLE;
            if (owner_q == GRANT_LSB) begin
              lsb_has_result_d = 1'b1;
              lsb_value_load_d = buf_next_s;
            end else begin
              if_done_d = 1'b1;
              if_data_d = buf_next_s;
            end
          end else begin
            state_d = ST_READ;
          end
        end
      end

      ST_WRITE: begin
        // Flush is ignored here so a committed store is never torn.
        if (width_q == 3'd0) begin
          state_d          = ST_IDLE;
          lsb_has_result_d = 1'b1;
          lsb_value_load_d = 32'd0;
        end else if (mem_wr_q) begin
          k_d = k_next_s;
          if (k_next_s == width_q) begin
            state_d          = ST_IDLE;
            lsb_has_result_d = 1'b1;
            lsb_value_load_d = 32'd0;
          end else begin
            mem_a_d    = addr_q + {29'd0, k_next_s};
            mem_dout_d = byte_of(store_q, k_next_s[1:0]);
            mem_wr_d   = !io_stall_s;
          end
        end else begin
          // Stalled on the I/O buffer: byte k stays pending on the bus.
          mem_wr_d = !io_stall_s;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers: reset overrides freeze, freeze holds everything.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q          <= ST_IDLE;
      last_grant_q     <= GRANT_FETCH;
      owner_q          <= 1'b0;
      addr_q           <= 32'd0;
      width_q          <= 3'd0;
      store_q          <= 32'd0;
      k_q              <= 3'd0;
      buf_q            <= 32'd0;
      if_ack_q         <= 1'b0;
      if_done_q        <= 1'b0;
      if_data_q        <= 32'd0;
      lsb_received_q   <= 1'b0;
      lsb_has_result_q <= 1'b0;
      lsb_value_load_q <= 32'd0;
      mem_dout_q       <= 8'd0;
      mem_a_q          <= 32'd0;
      mem_wr_q         <= 1'b0;
    end else if (rdy_in) begin
      state_q          <= state_d;
      last_grant_q     <= last_grant_d;
      owner_q          <= owner_d;
      addr_q           <= addr_d;
      width_q          <= width_d;
      store_q          <= store_d;
      k_q              <= k_d;
      buf_q            <= buf_d;
      if_ack_q         <= if_ack_d;
      if_done_q        <= if_done_d;
      if_data_q        <= if_data_d;
      lsb_received_q   <= lsb_received_d;
      lsb_has_result_q <= lsb_has_result_d;
      lsb_value_load_q <= lsb_value_load_d;
      mem_dout_q       <= mem_dout_d;
      mem_a_q          <= mem_a_d;
      mem_wr_q         <= mem_wr_d;
    end
  end

  assign if_ack         = if_ack_q;
  assign if_done        = if_done_q;
  assign if_data        = if_data_q;
  assign lsb_received   = lsb_received_q;
  assign lsb_has_result = lsb_has_result_q;
  assign lsb_value_load = lsb_value_load_q;
  assign mem_dout       = mem_dout_q;
  assign mem_a          = mem_a_q;
  assign mem_wr         = mem_wr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte RAM model and scoreboards for
// fetch results, LSB results and RAM writes.
module tb_mem_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear_in;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack, if_done;
  logic [31:0] if_data;
  logic        lsb_go_work, lsb_l_or_s;
  logic [2:0]  lsb_width;
  logic [31:0] lsb_address, lsb_value_store;
  logic        lsb_received, lsb_has_result;
  logic [31:0] lsb_value_load;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] exp_if_q[$];
  logic [31:0] exp_lsb_q[$];
  logic [39:0] exp_wr_q[$];

  // RAM model, frozen by rdy_in like the real one; 16-bit index is enough here.
  logic [7:0]  ram [0:65535];
  logic        pre_we = 1'b0;
  logic [15:0] pre_addr = 16'd0;
  logic [7:0]  pre_data = 8'd0;

  mem_arbiter #(.IO_BASE(32'h00030000)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_done(if_done),
    .if_data(if_data), .lsb_go_work(lsb_go_work), .lsb_l_or_s(lsb_l_or_s),
    .lsb_width(lsb_width), .lsb_address(lsb_address),
    .lsb_value_store(lsb_value_store), .lsb_received(lsb_received),
    .lsb_has_result(lsb_has_result), .lsb_value_load(lsb_value_load),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(posedge clk_in) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (rdy_in && mem_wr) ram[mem_a[15:0]] <= mem_dout;
    if (rdy_in) mem_din <= ram[mem_a[15:0]];
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // sel: 0 if_ack, 1 lsb_received, 2 if_done, 3 lsb_has_result
  task automatic wait_pulse(input int sel, input string tag, output int c);
    logic seen;
    seen = 1'b0;
    c = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      case (sel)
        0: seen = if_ack;
        1: seen = lsb_received;
        2: seen = if_done;
        default: seen = lsb_has_result;
      endcase
      if (seen) c = cyc;
    end
    checks++;
    assert (seen) else begin
      errors++;
      $error("FAIL %s: observed no pulse expected a pulse within 40 cycles", tag);
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we = 1'b1;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic lsb_req(input logic s, input logic [2:0] w, input logic [31:0] a,
                         input logic [31:0] v);
    lsb_l_or_s = s;
    lsb_width = w;
    lsb_address = a;
    lsb_value_store = v;
    lsb_go_work = 1'b1;
  endtask

  // Scoreboard side: compare every RAM write and every completion pulse.
  initial begin
    logic [39:0] ew;
    logic [31:0] ed;
    forever begin
      @(negedge clk_in);
      if (rdy_in) begin
        if (mem_wr) begin
          checks++;
          assert (exp_wr_q.size() > 0) else begin
            errors++;
            $error("FAIL wr_unexpected: observed write %h<=%h expected none", mem_a, mem_dout);
          end
          if (exp_wr_q.size() > 0) begin
            ew = exp_wr_q.pop_front();
            checks++;
            assert ({mem_a, mem_dout} === ew) else begin
              errors++;
              $error("FAIL wr_byte: observed %h expected %h", {mem_a, mem_dout}, ew);
            end
          end
        end
        if (if_done) begin
          checks++;
          assert (exp_if_q.size() > 0) else begin
            errors++;
            $error("FAIL if_done_unexpected: observed data %h expected no pulse", if_data);
          end
          if (exp_if_q.size() > 0) begin
            ed = exp_if_q.pop_front();
            checks++;
            assert (if_data === ed) else begin
              errors++;
              $error("FAIL if_data: observed %h expected %h", if_data, ed);
            end
          end
        end
        if (lsb_has_result) begin
          checks++;
          assert (exp_lsb_q.size() > 0) else begin
            errors++;
            $error("FAIL lsb_unexpected: observed data %h expected no pulse", lsb_value_load);
          end
          if (exp_lsb_q.size() > 0) begin
            ed = exp_lsb_q.pop_front();
            checks++;
            assert (lsb_value_load === ed) else begin
              errors++;
              $error("FAIL lsb_value: observed %h expected %h", lsb_value_load, ed);
            end
          end
        end
      end
    end
  end

  initial begin
    int c0, c1, c2, npulse;
    rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0;
    if_req = 1'b0; if_addr = 32'd0;
    lsb_go_work = 1'b0; lsb_l_or_s = 1'b0; lsb_width = 3'd0;
    lsb_address = 32'd0; lsb_value_store = 32'd0; io_buffer_full = 1'b0;
    tick(); tick();
    chk("reset_outputs", {if_ack, if_done, if_data, lsb_received, lsb_has_result,
                          lsb_value_load, mem_dout, mem_a, mem_wr}, 64'd0);
    rst_in = 1'b0;

    preload(16'h0100, 8'h13); preload(16'h0101, 8'h05);
    preload(16'h0102, 8'h00); preload(16'h0103, 8'h00);
    preload(16'h0204, 8'hFE); preload(16'h0205, 8'hFF);
    preload(16'h0300, 8'h11); preload(16'h0301, 8'h22);
    preload(16'h0302, 8'h33); preload(16'h0303, 8'h44);

    // Fetch only
    exp_if_q.push_back(32'h00000513);
    if_addr = 32'h100; if_req = 1'b1;
    wait_pulse(0, "fetch_ack", c0);
    if_req = 1'b0;
    chk("fetch_a0", mem_a, 32'h100);
    tick(); chk("fetch_ack_one_cycle", if_ack, 1'b0); chk("fetch_a1", mem_a, 32'h101);
    tick(); chk("fetch_a2", mem_a, 32'h102);
    tick(); chk("fetch_a3", mem_a, 32'h103);
    chk("read_no_wr", mem_wr, 1'b0);
    wait_pulse(2, "fetch_done", c1);
    chk("fetch_latency", c1 - c0, 5);

    // Simultaneous requests after reset: LSB first, then fetch
    rst_in = 1'b1; tick(); rst_in = 1'b0;
    exp_lsb_q.push_back(32'h0000FFFE);
    exp_if_q.push_back(32'h00000513);
    if_addr = 32'h100; if_req = 1'b1;
    lsb_req(1'b0, 3'd2, 32'h204, 32'd0);
    wait_pulse(1, "arb_lsb_received", c0);
    chk("arb_no_fetch_ack", if_ack, 1'b0);
    lsb_go_work = 1'b0;
    wait_pulse(3, "arb_lsb_done", c1);
    chk("load2_latency", c1 - c0, 3);
    wait_pulse(0, "arb_fetch_ack", c2);
    if_req = 1'b0;
    chk("arb_gap", c2 - c1, 1);
    wait_pulse(2, "arb_fetch_done", c0);

    // Store word
    exp_wr_q.push_back({32'h1000, 8'hEF}); exp_wr_q.push_back({32'h1001, 8'hBE});
    exp_wr_q.push_back({32'h1002, 8'hAD}); exp_wr_q.push_back({32'h1003, 8'hDE});
    exp_lsb_q.push_back(32'd0);
    lsb_req(1'b1, 3'd4, 32'h1000, 32'hDEADBEEF);
    wait_pulse(1, "store_received", c0);
    lsb_go_work = 1'b0;
    wait_pulse(3, "store_done", c1);
    chk("store_latency", c1 - c0, 4);
    tick();
    chk("store_wr_drained", exp_wr_q.size(), 0);

    // Read it back
    exp_lsb_q.push_back(32'hDEADBEEF);
    lsb_req(1'b0, 3'd4, 32'h1000, 32'd0);
    wait_pulse(1, "readback_received", c0);
    lsb_go_work = 1'b0;
    wait_pulse(3, "readback_done", c1);

    // Null access
    exp_lsb_q.push_back(32'd0);
    lsb_req(1'b0, 3'd0, 32'h300, 32'd0);
    wait_pulse(1, "null_received", c0);
    lsb_go_work = 1'b0;
    wait_pulse(3, "null_done", c1);
    chk("null_latency", c1 - c0, 1);

    // I/O store stalled by a full buffer for three cycles
    io_buffer_full = 1'b1;
    exp_wr_q.push_back({32'h30000, 8'h41});
    exp_lsb_q.push_back(32'd0);
    lsb_req(1'b1, 3'd1, 32'h30000, 32'h12345641);
    wait_pulse(1, "io_received", c0);
    lsb_go_work = 1'b0;
    chk("io_stall0", mem_wr, 1'b0);
    tick(); chk("io_stall1", mem_wr, 1'b0);
    tick(); chk("io_stall2", mem_wr, 1'b0);
    io_buffer_full = 1'b0;
    tick(); chk("io_write", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h30000, 8'h41});
    wait_pulse(3, "io_done", c1);
    chk("io_latency", c1 - c0, 4);

    // Flush during a fetch after byte 2 is presented
    if_addr = 32'h300; if_req = 1'b1;
    wait_pulse(0, "clr_fetch_ack", c0);
    if_req = 1'b0;
    tick(); tick();
    chk("clr_fetch_a2", mem_a, 32'h302);
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
    chk("clr_fetch_outputs", {if_done, if_data, mem_a, mem_wr}, 65'd0);
    npulse = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (if_done) npulse++;
    end
    chk("clr_fetch_no_done", npulse, 0);
    exp_if_q.push_back(32'h44332211);
    if_addr = 32'h300; if_req = 1'b1;
    c2 = cyc;
    wait_pulse(0, "clr_refetch_ack", c0);
    if_req = 1'b0;
    chk("clr_idle_accept", c0 - c2, 1);
    wait_pulse(2, "clr_refetch_done", c1);

    // Same flush during a 4-byte store: all bytes still land
    exp_wr_q.push_back({32'h1100, 8'h04}); exp_wr_q.push_back({32'h1101, 8'h03});
    exp_wr_q.push_back({32'h1102, 8'h02}); exp_wr_q.push_back({32'h1103, 8'h01});
    exp_lsb_q.push_back(32'd0);
    lsb_req(1'b1, 3'd4, 32'h1100, 32'h01020304);
    wait_pulse(1, "clr_store_received", c0);
    lsb_go_work = 1'b0;
    tick(); tick();
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
    wait_pulse(3, "clr_store_done", c1);
    chk("clr_store_latency", c1 - c0, 4);
    chk("clr_store_all_bytes", exp_wr_q.size(), 0);

    // Two-cycle freeze in the middle of a load
    exp_lsb_q.push_back(32'h44332211);
    lsb_req(1'b0, 3'd4, 32'h300, 32'd0);
    wait_pulse(1, "rdy_received", c0);
    lsb_go_work = 1'b0;
    tick(); tick();
    chk("rdy_a_before", mem_a, 32'h302);
    rdy_in = 1'b0;
    tick(); chk("rdy_a_hold1", mem_a, 32'h302);
    tick(); chk("rdy_a_hold2", mem_a, 32'h302);
    rdy_in = 1'b1;
    wait_pulse(3, "rdy_done", c1);
    chk("rdy_latency", c1 - c0, 7);

    // Reset in the middle of a store: two bytes go out, then nothing
    exp_wr_q.push_back({32'h1200, 8'hBE}); exp_wr_q.push_back({32'h1201, 8'hBA});
    lsb_req(1'b1, 3'd4, 32'h1200, 32'hCAFEBABE);
    wait_pulse(1, "rst_store_received", c0);
    lsb_go_work = 1'b0;
    tick();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    chk("rst_drops_wr", mem_wr, 1'b0);
    npulse = 0;
    for (int i = 0; i < 6; i++) begin
      if (lsb_has_result || mem_wr) npulse++;
      tick();
    end
    chk("rst_no_pulse", npulse, 0);

    chk("if_queue_empty", exp_if_q.size(), 0);
    chk("lsb_queue_empty", exp_lsb_q.size(), 0);
    chk("wr_queue_empty", exp_wr_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port memory controller between the instruction fetcher, the load/store buffer (LSB) and the byte-wide unified RAM.
- Accepts one request at a time and sequences it as 1–4 byte accesses, lowest address first (little-endian).
- Returns the assembled little-endian word to the requester.
- Arbitrates fetch vs LSB round-robin; handles pipeline flush and the I/O output-buffer back-pressure.

Parameters:
IO_BASE, 32'h00030000, first address of the I/O region; stores to IO_BASE..IO_BASE+7 obey io_buffer_full.

Ports:
clk_in  in  1  clock
rst_in  in  1  synchronous active-high reset
rdy_in  in  1  global ready; low = freeze
clear_in  in  1  pipeline flush (mispredict)
if_req  in  1  fetch request, level
if_addr  in  32  fetch byte address
if_ack  out  1  one-cycle pulse: fetch request accepted
if_done  out  1  one-cycle pulse: if_data valid
if_data  out  32  fetched instruction word
lsb_go_work  in  1  LSB request, level
lsb_l_or_s  in  1  0 = load, 1 = store
lsb_width  in  3  byte count: 1, 2 or 4; 0 = null access
lsb_address  in  32  byte address
lsb_value_store  in  32  store data; low lsb_width bytes are used
lsb_received  out  1  one-cycle pulse: LSB request accepted
lsb_has_result  out  1  one-cycle pulse: access complete
lsb_value_load  out  32  zero-extended load data; 0 for stores
mem_din  in  8  RAM read data, valid the cycle after mem_a
mem_dout  out  8  RAM write data
mem_a  out  32  RAM byte address
mem_wr  out  1  1 = write mem_dout to mem_a this cycle
io_buffer_full  in  1  I/O FIFO full

Behaviour:
- Reset values: FSM = IDLE; all outputs 0; last_grant = FETCH, so the LSB wins the first tie. A reset mid-access abandons the access with no pulse and drops mem_wr the next cycle.
- rdy_in low: all registers hold. The RAM is frozen by the same rdy_in, so no byte is re-issued on resume. rst_in overrides rdy_in.
- FSM states: IDLE, READ, WRITE.
- IDLE accept rule:
  - A request is accepted only in IDLE, only when clear_in = 0.
  - With one requester, grant it. With both, grant the one not equal to last_grant, then update last_grant.
  - On the accept edge, latch addr, width (fetch = 4), store data and owner; set byte counter k = 0.
  - The matching ack/received pulse is visible in the following cycle.
- READ (N = width):
  - Byte k's address is driven in cycle k+1 after the accept edge.
  - mem_din for byte k is sampled at edge k+2 into bits [8k+7:8k]; unused upper bytes are 0.
  - The done pulse (if_done or lsb_has_result) plus data is registered at edge N+1 and held one cycle; the FSM returns to IDLE on that edge.
  - 4-byte load: done visible 5 edges after accept.
- WRITE:
  - Byte k is driven with mem_a = addr+k and mem_wr = 1 in cycle k+1.
  - lsb_has_result is registered at edge N with lsb_value_load = 0; FSM returns to IDLE.
  - I/O stall: if the latched address is in [IO_BASE, IO_BASE+7] and io_buffer_full = 1, hold mem_wr = 0 and do not advance k until io_buffer_full = 0.
- Null access: LSB width 0 → received pulse, no RAM traffic, lsb_has_result with value 0 on the next edge.
- Next accept: earliest on the edge after the done pulse is registered, giving one IDLE cycle minimum. Requesters re-evaluate their request from the ack/received pulse.
- clear_in = 1 sampled:
  - READ (fetch or load): abort to IDLE, suppress done, zero the outputs.
  - WRITE: continue to completion; committed stores are never torn.
  - IDLE: no accept on that edge.
- mem_wr is 0 in IDLE and READ at all times.
- Addresses increment modulo 2^32.

Test Plan:
- Fetch only, if_addr = 0x100, RAM bytes 13 05 00 00 → if_ack pulse after the accept edge; mem_a = 0x100..0x103 on consecutive cycles; if_done after edge 5 with if_data = 0x00000513.
- Simultaneous if_req and lsb_go_work load (width 2, addr 0x204, bytes FE FF) after reset → LSB granted first, lsb_value_load = 0x0000FFFE; fetch granted next with no idle gap beyond one cycle.
- LSB store, width 4, addr 0x1000, data 0xDEADBEEF → mem_wr high 4 cycles writing EF BE AD DE to 0x1000..0x1003; lsb_has_result pulse with value 0.
- Store byte 0x41 to 0x30000 with io_buffer_full = 1 for 3 cycles → mem_wr stays 0 for those cycles; write then issues; has_result follows.
- clear_in asserted during a fetch after byte 2 is presented → no if_done, FSM back in IDLE. The same clear during a 4-byte store → all 4 bytes are written.
- rdy_in low for 2 cycles mid-load → mem_a and the counter hold; result identical to the no-stall case, delayed by 2 cycles. rst_in mid-store → mem_wr = 0 the next cycle, no pulse.
